// File: rtl/tl_probe_pkg.sv
// Shared types for the TileLink channel-B probe sequencer: FSM states, opcodes,
// cap/permission/report encodings and the permission downgrade rule.
package tl_probe_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WAIT, S_UPDATE, S_DREQ, S_DSEND, S_ACK
  } state_e;

  localparam logic [2:0] PROBE          = 3'd6;
  localparam logic [2:0] PROBE_ACK      = 3'd4;
  localparam logic [2:0] PROBE_ACK_DATA = 3'd5;

  typedef enum logic [1:0] {CAP_TOT = 2'd0, CAP_TOB = 2'd1, CAP_TON = 2'd2} cap_e;
  typedef enum logic [1:0] {PERM_N = 2'd0, PERM_B = 2'd1, PERM_T = 2'd2} perm_e;
  typedef enum logic [2:0] {
    RPT_TTOB = 3'd0, RPT_TTON = 3'd1, RPT_BTON = 3'd2,
    RPT_TTOT = 3'd3, RPT_BTOB = 3'd4, RPT_NTON = 3'd5
  } rpt_e;

  typedef struct packed {
    perm_e perm;
    rpt_e  rpt;
  } perm_upd_t;

  // new = min(current, 2 - cap); any cap beyond toB (including 3) caps at N
  function automatic perm_upd_t perm_update(input logic [1:0] perm, input logic [1:0] cap);
    perm_upd_t  r;
    logic [1:0] lim;
    case (cap)
      CAP_TOT: lim = PERM_T;
      CAP_TOB: lim = PERM_B;
      default: lim = PERM_N;
    endcase
    r.perm = (perm < lim) ? perm_e'(perm) : perm_e'(lim);
    case ({perm, r.perm})
      {PERM_T, PERM_T}: r.rpt = RPT_TTOT;
      {PERM_T, PERM_B}: r.rpt = RPT_TTOB;
      {PERM_T, PERM_N}: r.rpt = RPT_TTON;
      {PERM_B, PERM_B}: r.rpt = RPT_BTOB;
      {PERM_B, PERM_N}: r.rpt = RPT_BTON;
      default:          r.rpt = RPT_NTON;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tl_probe_ctrl.sv
// Channel-B probe sequencer: tag lookup, permission downgrade, ProbeAck/ProbeAckData on C.
// Define TL_PROBE_ERR_CHECK_EN to add the sticky `err` output for malformed B requests.
module tl_probe_ctrl
  import tl_probe_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_SIZE = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [2:0]        b_opcode,
  input  logic [1:0]        b_param,
  input  logic [3:0]        b_size,
  input  logic              b_source,
  input  logic [ADDR_W-1:0] b_address,
  output logic              lkp_valid,
  input  logic              lkp_ready,
  output logic [ADDR_W-1:0] lkp_address,
  input  logic              lkp_resp_valid,
  input  logic [1:0]        lkp_perm,
  input  logic              lkp_dirty,
  output logic              perm_wr,
  output logic [1:0]        perm_new,
  output logic              dat_req,
  output logic [3:0]        dat_beat,
  input  logic [DATA_W-1:0] dat_rdata,
  output logic              c_valid,
  input  logic              c_ready,
  output logic [2:0]        c_opcode,
  output logic [2:0]        c_param,
  output logic [3:0]        c_size,
  output logic              c_source,
  output logic [ADDR_W-1:0] c_address,
  output logic [DATA_W-1:0] c_data,
`ifdef TL_PROBE_ERR_CHECK_EN
  output logic              err,
`endif
  output logic              busy
);

  localparam logic [3:0] BB_LOG = 4'($clog2(DATA_W / 8));
  localparam logic [3:0] MAX_SZ = 4'(MAX_SIZE);

  state_e              state_q, state_d;
  logic [1:0]          cap_q;
  logic [3:0]          size_q, last_q, cnt_q, cnt_d;
  logic                src_q, wr_q, dtx_q, first_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  perm_e               nperm_q;
  rpt_e                rpt_q;
  perm_upd_t           upd;
  logic                bad, b_fire;
  logic [3:0]          sz_clamp, nlast;

  assign b_fire   = b_valid && (state_q == S_IDLE);
  assign upd      = perm_update(lkp_perm, cap_q);
  assign sz_clamp = (b_size > MAX_SZ) ? MAX_SZ : b_size;
  // last beat index = beats - 1; sub-beat sizes still take one beat
  assign nlast    = (sz_clamp <= BB_LOG) ? 4'd0 : (4'd1 << (sz_clamp - BB_LOG)) - 4'd1;

`ifdef TL_PROBE_ERR_CHECK_EN
  logic err_q;
  assign bad = (b_opcode != PROBE) || (b_param == 2'd3);
  assign err = err_q;
  always_ff @(posedge clock) begin
    if (reset)               err_q <= 1'b0;
    else if (b_fire && bad)  err_q <= 1'b1;
  end
`else
  logic unused_opcode;
  assign bad           = 1'b0;
  assign unused_opcode = ^b_opcode;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      size_q  <= '0;
      src_q   <= 1'b0;
      addr_q  <= '0;
      last_q  <= '0;
      nperm_q <= PERM_N;
      rpt_q   <= RPT_TTOB;
      wr_q    <= 1'b0;
      dtx_q   <= 1'b0;
      first_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= (state_q == S_DREQ);
      if (b_fire) begin
        cap_q  <= b_param;
        size_q <= b_size;
        src_q  <= b_source;
        addr_q <= b_address;
        last_q <= nlast;
        rpt_q  <= RPT_NTON;
      end
      if (state_q == S_WAIT && lkp_resp_valid) begin
        nperm_q <= upd.perm;
        rpt_q   <= upd.rpt;
        wr_q    <= (upd.perm != lkp_perm);
        dtx_q   <= lkp_dirty && (lkp_perm == PERM_T);
      end
      // read data is only present in the first DSEND cycle; hold it until the fire
      if (state_q == S_DSEND && first_q) data_q <= dat_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (b_valid) begin
                  state_d = bad ? S_ACK : S_LOOKUP;
                  cnt_d   = '0;
                end
      S_LOOKUP: if (lkp_ready) state_d = S_WAIT;
      S_WAIT:   if (lkp_resp_valid) state_d = S_UPDATE;
      S_UPDATE: state_d = dtx_q ? S_DREQ : S_ACK;
      S_DREQ:   state_d = S_DSEND;
      S_DSEND:  if (c_ready) begin
                  if (cnt_q == last_q) state_d = S_IDLE;
                  else begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = S_DREQ;
                  end
                end
      S_ACK:    if (c_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    b_ready     = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    lkp_valid   = (state_q == S_LOOKUP);
    lkp_address = addr_q;
    perm_wr     = (state_q == S_UPDATE) && wr_q;
    perm_new    = nperm_q;
    dat_req     = (state_q == S_DREQ);
    dat_beat    = cnt_q;
    c_valid     = (state_q == S_DSEND) || (state_q == S_ACK);
    c_opcode    = (state_q == S_DSEND) ? PROBE_ACK_DATA : PROBE_ACK;
    c_param     = rpt_q;
    c_size      = size_q;
    c_source    = src_q;
    c_address   = addr_q;
    c_data      = '0;
    if (state_q == S_DSEND) c_data = first_q ? dat_rdata : data_q;
  end

endmodule

// File: tb/tb_tl_probe_ctrl.sv
// Self-checking bench for tl_probe_ctrl: transaction-level model with a per-cycle compare process.
module tb_tl_probe_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        b_valid, b_ready, b_source;
  logic [2:0]  b_opcode;
  logic [1:0]  b_param;
  logic [3:0]  b_size;
  logic [31:0] b_address;
  logic        lkp_valid, lkp_ready, lkp_resp_valid, lkp_dirty;
  logic [31:0] lkp_address;
  logic [1:0]  lkp_perm;
  logic        perm_wr;
  logic [1:0]  perm_new;
  logic        dat_req;
  logic [3:0]  dat_beat;
  logic [31:0] dat_rdata;
  logic        c_valid, c_ready, c_source;
  logic [2:0]  c_opcode, c_param;
  logic [3:0]  c_size;
  logic [31:0] c_address, c_data;
  logic        busy;
`ifdef TL_PROBE_ERR_CHECK_EN
  logic        err;
`endif

  always #5 clock = ~clock;

  tl_probe_ctrl #(.ADDR_W(32), .DATA_W(32), .MAX_SIZE(6)) dut (
    .clock(clock), .reset(reset),
    .b_valid(b_valid), .b_ready(b_ready), .b_opcode(b_opcode), .b_param(b_param),
    .b_size(b_size), .b_source(b_source), .b_address(b_address),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_address(lkp_address),
    .lkp_resp_valid(lkp_resp_valid), .lkp_perm(lkp_perm), .lkp_dirty(lkp_dirty),
    .perm_wr(perm_wr), .perm_new(perm_new),
    .dat_req(dat_req), .dat_beat(dat_beat), .dat_rdata(dat_rdata),
    .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode), .c_param(c_param),
    .c_size(c_size), .c_source(c_source), .c_address(c_address), .c_data(c_data),
`ifdef TL_PROBE_ERR_CHECK_EN
    .err(err),
`endif
    .busy(busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  prm;
    logic [3:0]  sz;
    logic        src;
    logic [31:0] addr;
    logic [31:0] data;
  } cbeat_t;

  int          nchk = 0, nerr = 0;
  cbeat_t      exp_c[$];
  logic [31:0] exp_lk[$];
  logic [1:0]  exp_pw[$];
  logic [3:0]  exp_beat[$];
  logic [31:0] mem [16];
  logic        prev_req = 1'b0;
  logic [3:0]  prev_beat = 4'd0;
  bit          sticky_err = 1'b0;

  // per-transaction observations used by the literal checks
  int          lat, pw_cnt, lk_cnt, nbeats;
  logic [1:0]  pw_val;
  logic [2:0]  f_op, f_param;
  logic [31:0] f_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    nchk++;
    nerr++;
    $display("FAIL %s", nm);
  endtask

  task automatic cmp_beat(input string nm, input cbeat_t a, input cbeat_t e);
    chk({nm, ".opcode"},  a.op,   e.op);
    chk({nm, ".param"},   a.prm,  e.prm);
    chk({nm, ".size"},    a.sz,   e.sz);
    chk({nm, ".source"},  a.src,  e.src);
    chk({nm, ".address"}, a.addr, e.addr);
    chk({nm, ".data"},    a.data, e.data);
  endtask

  function automatic logic [2:0] rpt_of(input logic [1:0] cur, input logic [1:0] nw);
    if (cur == 2'd2 && nw == 2'd2) return 3'd3;
    if (cur == 2'd2 && nw == 2'd1) return 3'd0;
    if (cur == 2'd2 && nw == 2'd0) return 3'd1;
    if (cur == 2'd1 && nw == 2'd1) return 3'd4;
    if (cur == 2'd1 && nw == 2'd0) return 3'd2;
    return 3'd5;
  endfunction

  // advance one cycle; data array answers one cycle after each dat_req, garbage otherwise
  task automatic tick();
    @(posedge clock);
    #1;
    dat_rdata = prev_req ? mem[prev_beat] : $urandom;
    prev_req  = dat_req;
    prev_beat = dat_beat;
  endtask

  // compare process: every cycle, mid-cycle
  cbeat_t hold, cur;
  bit     pend = 1'b0;
  initial forever begin
    @(negedge clock);
    if (reset) pend = 1'b0;
    else begin
      chk("b_ready_vs_busy", b_ready, !busy);
      if (lkp_valid && lkp_ready) begin
        if (exp_lk.size() == 0) fail("unexpected_lookup");
        else chk("lkp_address", lkp_address, exp_lk.pop_front());
      end
      if (perm_wr) begin
        if (exp_pw.size() == 0) fail("unexpected_perm_wr");
        else chk("perm_new", perm_new, exp_pw.pop_front());
      end
      if (dat_req) begin
        if (pend) fail("dat_req_while_beat_pending");
        if (exp_beat.size() == 0) fail("unexpected_dat_req");
        else chk("dat_beat", dat_beat, exp_beat.pop_front());
      end
      cur = '{c_opcode, c_param, c_size, c_source, c_address, c_data};
      if (pend) begin
        chk("c_valid_held", c_valid, 1'b1);
        if (c_valid) cmp_beat("c_stable", cur, hold);
      end
      if (c_valid && c_ready) begin
        if (exp_c.size() == 0) fail("unexpected_c_beat");
        else cmp_beat("c_beat", cur, exp_c.pop_front());
        pend = 1'b0;
      end else if (c_valid) begin
        pend = 1'b1;
        hold = cur;
      end else pend = 1'b0;
    end
  end

  task automatic run_probe(input logic [2:0] op, input logic [1:0] cap, input logic [3:0] sz,
                           input logic src, input logic [31:0] addr, input logic [1:0] perm,
                           input logic dirty, input bit fast, input int stall_beat,
                           input int stall_len, input int rst_beat);
    bit         bad, data, fired, armed, done, seen_c;
    int         nb, rwait, beats, stall_cnt, fire_cyc;
    logic [1:0] lim, np;
    cbeat_t     e;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
`ifdef TL_PROBE_ERR_CHECK_EN
    bad = (op != 3'd6) || (cap == 2'd3);
`else
    bad = 1'b0;
`endif
    if (bad) begin
      e = '{3'd4, 3'd5, sz, src, addr, 32'd0};
      exp_c.push_back(e);
      nb = 1;
      sticky_err = 1'b1;
    end else begin
      lim = (cap == 2'd0) ? 2'd2 : (cap == 2'd1) ? 2'd1 : 2'd0;
      np  = (perm < lim) ? perm : lim;
      exp_lk.push_back(addr);
      if (np != perm) exp_pw.push_back(np);
      data = dirty && (perm == 2'd2);
      nb = 1;
      if (data) nb = (1 << ((sz > 4'd6) ? 4'd6 : sz)) / 4;
      if (nb < 1) nb = 1;
      for (int i = 0; i < nb; i++) begin
        e = '{data ? 3'd5 : 3'd4, rpt_of(perm, np), sz, src, addr, data ? mem[i] : 32'd0};
        exp_c.push_back(e);
        if (data) exp_beat.push_back(4'(i));
      end
    end
    pw_cnt = 0; lk_cnt = 0; lat = -1; beats = 0; stall_cnt = 0; rwait = 0; fire_cyc = 0;
    fired = 0; armed = 0; done = 0; seen_c = 0;
    b_valid = 1'b1; b_opcode = op; b_param = cap; b_size = sz; b_source = src; b_address = addr;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      lkp_ready      = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
      lkp_resp_valid = 1'b0;
      lkp_perm       = 2'($urandom);
      lkp_dirty      = 1'($urandom);
      if (armed) begin
        if (rwait == 0) begin
          lkp_resp_valid = 1'b1; lkp_perm = perm; lkp_dirty = dirty; armed = 0;
        end else rwait--;
      end
      c_ready = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (c_valid && beats == stall_beat && stall_cnt < stall_len) begin
        c_ready = 1'b0;
        stall_cnt++;
      end
      if (c_valid && beats == rst_beat) begin
        reset = 1'b1; c_ready = 1'b0; done = 1;
        exp_c.delete(); exp_beat.delete(); exp_pw.delete(); exp_lk.delete();
      end
      if (b_valid && b_ready) begin fired = 1; fire_cyc = cyc; end
      if (lkp_valid && lkp_ready) begin
        lk_cnt++; armed = 1; rwait = fast ? 0 : int'($urandom_range(0, 3));
      end
      if (perm_wr) begin pw_cnt++; pw_val = perm_new; end
      if (c_valid && !seen_c) begin
        seen_c = 1; lat = cyc - fire_cyc; f_op = c_opcode; f_param = c_param; f_addr = c_address;
      end
      if (c_valid && c_ready) begin
        beats++;
        if (beats == nb) done = 1;
      end
      tick();
      if (fired) b_valid = 1'b0;
    end
    reset = 1'b0;
    if (!done) fail("transaction_timeout");
    nbeats = beats;
  endtask

  initial begin
    reset = 1'b1; b_valid = 0; b_opcode = 0; b_param = 0; b_size = 0; b_source = 0;
    b_address = 0; lkp_ready = 0; lkp_resp_valid = 0; lkp_perm = 0; lkp_dirty = 0;
    dat_rdata = 0; c_ready = 0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst.b_ready", b_ready, 1'b1);
    chk("rst.busy", busy, 1'b0);
    chk("rst.lkp_valid", lkp_valid, 1'b0);
    chk("rst.perm_wr", perm_wr, 1'b0);
    chk("rst.dat_req", dat_req, 1'b0);
    chk("rst.c_valid", c_valid, 1'b0);
    chk("rst.c_data", c_data, 32'd0);
    chk("rst.c_address", c_address, 32'd0);
    chk("rst.dat_beat", dat_beat, 4'd0);
`ifdef TL_PROBE_ERR_CHECK_EN
    chk("rst.err", err, 1'b0);
`endif

    // toN on a clean T line, best-case handshakes
    run_probe(3'd6, 2'd2, 4'd6, 1'b0, 32'h8000_0040, 2'd2, 1'b0, 1'b1, -1, 0, -1);
    chk("t1.latency", lat, 4);
    chk("t1.pw_cnt", pw_cnt, 1);
    chk("t1.perm_new", pw_val, 2'd0);
    chk("t1.c_opcode", f_op, 3'd4);
    chk("t1.c_param", f_param, 3'd1);
    chk("t1.c_address", f_addr, 32'h8000_0040);

    // toB on a dirty T line: full 64-byte writeback
    run_probe(3'd6, 2'd1, 4'd6, 1'b1, 32'h1000_0000, 2'd2, 1'b1, 1'b1, -1, 0, -1);
    chk("t2.perm_new", pw_val, 2'd1);
    chk("t2.c_opcode", f_op, 3'd5);
    chk("t2.c_param", f_param, 3'd0);
    chk("t2.beats", nbeats, 16);

    // toT on a B line: nothing to downgrade
    run_probe(3'd6, 2'd0, 4'd2, 1'b0, 32'h2000_0080, 2'd1, 1'b0, 1'b0, -1, 0, -1);
    chk("t3.pw_cnt", pw_cnt, 0);
    chk("t3.c_param", f_param, 3'd4);

    // back-pressure: c_ready low for 5 cycles on beat 3
    run_probe(3'd6, 2'd2, 4'd6, 1'b0, 32'h3000_0100, 2'd2, 1'b1, 1'b1, 3, 5, -1);
    chk("t4.beats", nbeats, 16);
    chk("t4.c_param", f_param, 3'd1);

    // reset during beat 7 aborts, then a normal probe
    run_probe(3'd6, 2'd1, 4'd6, 1'b0, 32'h4000_0000, 2'd2, 1'b1, 1'b0, -1, 0, 7);
    chk("t5.c_valid", c_valid, 1'b0);
    chk("t5.b_ready", b_ready, 1'b1);
    chk("t5.busy", busy, 1'b0);
    run_probe(3'd6, 2'd2, 4'd3, 1'b1, 32'h4000_0040, 2'd1, 1'b1, 1'b0, -1, 0, -1);
    chk("t6.c_param", f_param, 3'd2);
    chk("t6.c_opcode", f_op, 3'd4);

`ifdef TL_PROBE_ERR_CHECK_EN
    run_probe(3'd4, 2'd0, 4'd6, 1'b0, 32'h5000_0000, 2'd2, 1'b1, 1'b0, -1, 0, -1);
    chk("e1.err", err, 1'b1);
    chk("e1.lookups", lk_cnt, 0);
    chk("e1.pw_cnt", pw_cnt, 0);
    chk("e1.c_param", f_param, 3'd5);
    run_probe(3'd6, 2'd2, 4'd6, 1'b0, 32'h5000_0040, 2'd2, 1'b0, 1'b0, -1, 0, -1);
    chk("e2.err_sticky", err, 1'b1);
`endif

    for (int n = 0; n < 80; n++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) < 8) ? 3'd6 : 3'($urandom);
      run_probe(op, 2'($urandom), 4'($urandom_range(0, 9)), 1'($urandom), $urandom,
                2'($urandom_range(0, 2)), 1'($urandom), 1'b0, int'($urandom_range(0, 15)),
                int'($urandom_range(0, 4)), -1);
    end
`ifdef TL_PROBE_ERR_CHECK_EN
    chk("final.err", err, sticky_err);
`endif

    repeat (2) tick();
    chk("left.c_beats", exp_c.size(), 0);
    chk("left.lookups", exp_lk.size(), 0);
    chk("left.perm_wr", exp_pw.size(), 0);
    chk("left.dat_req", exp_beat.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
